kyber_pk_streamer: RTL

- Server-side transmitter feeding the client's public-key receive port (client inputs wen / din / req_pk).
- Buffers the encoded public key produced by server key generation, one 32-bit word per load beat.
- On the client's req_pk request, streams the buffered key out as a contiguous valid/dout burst.
- Sits between server keygen and the server->client link; one instance per server.

---
 rtl/kyber_link_pkg.sv | 27 ++
 rtl/kyber_pk_ram.sv | 46 ++++
 rtl/kyber_pk_streamer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/kyber_link_pkg.sv
// Shared definitions for the Kyber server/client link: FSM encoding,
// legal security ranks and public-key word counts.
package kyber_link_pkg;

  typedef logic [1:0] pk_state_t;

  localparam pk_state_t StIdle  = 2'd0;
  localparam pk_state_t StLoad  = 2'd1;
  localparam pk_state_t StReady = 2'd2;
  localparam pk_state_t StSend  = 2'd3;

  localparam logic [2:0] K_MIN = 3'd2;
  localparam logic [2:0] K_MAX = 3'd4;

  localparam int unsigned POLY_WORDS = 96;
  localparam int unsigned RHO_WORDS  = 8;

  // Encoded public-key length in 32-bit words for rank k.
  function automatic int unsigned pk_words(input logic [2:0] k);
    return 32'(k) * POLY_WORDS + RHO_WORDS;
  endfunction

  function automatic logic k_legal(input logic [2:0] k);
    return (k >= K_MIN) && (k <= K_MAX);
  endfunction

endpackage

// File: rtl/kyber_pk_ram.sv
// Simple dual-port key buffer: one write port, one registered read port
// (1-cycle latency). Read register has a reset so dout is 0 out of reset.
module kyber_pk_ram #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q, rdata_d;

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read data holds when no read is issued.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  // Registered read output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/kyber_pk_streamer.sv
// Server-side public-key streamer: buffers the keygen output and bursts it
// to the client on req_pk. Define KYBER_PK_CHKSUM_EN to append an XOR
// checksum word after the key words in every burst.
module kyber_pk_streamer
  import kyber_link_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_WORDS = 392,
  parameter int unsigned AW        = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    k,
  input  logic          load_start,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          ready_pk,
  input  logic          req_pk,
  output logic          valid,
  output logic [DW-1:0] dout,
  output logic          err
);

  localparam logic [AW-1:0] AddrOne = AW'(1);

  pk_state_t     state_q, state_d;
  logic [AW-1:0] n_q, n_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [AW-1:0] total;
  logic          pend_q, pend_d;
  logic          req_q;
  logic          err_q, err_d;
  logic          valid_q, valid_d;
  logic          ram_we, ram_re;
  logic [DW-1:0] ram_rdata;
  logic          k_ok;
  logic [AW-1:0] n_new;

  assign n_new = AW'(pk_words(k));
  // Ranks whose key would not fit the buffer are rejected like illegal ones.
  assign k_ok  = k_legal(k) && (pk_words(k) <= MAX_WORDS);

`ifdef KYBER_PK_CHKSUM_EN
  logic [DW-1:0] chk_q, chk_d;
  logic          sel_chk_q, sel_chk_d;
  assign total = n_q + AddrOne;
`else
  assign total = n_q;
`endif

  // Next-state logic: load sequencing, request tracking and burst reads.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    wr_addr_d = wr_addr_q;
    rd_cnt_d  = rd_cnt_q;
    pend_d    = pend_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
`ifdef KYBER_PK_CHKSUM_EN
    chk_d     = chk_q;
    sel_chk_d = sel_chk_q;
`endif
    if (load_start && (state_q != StSend)) begin
      if (k_ok) begin
        state_d   = StLoad;
        n_d       = n_new;
        wr_addr_d = '0;
        err_d     = 1'b0;
        // A request already in flight survives a reload; the client still wants a key.
        pend_d    = (state_q == StIdle) ? 1'b0 : (pend_q | req_q);
`ifdef KYBER_PK_CHKSUM_EN
        chk_d     = '0;
`endif
      end else begin
        state_d = StIdle;
        err_d   = 1'b1;
        pend_d  = 1'b0;
      end
    end else begin
      case (state_q)
        StLoad: begin
          if (req_q) begin
            pend_d = 1'b1;
          end
          if (ld_valid) begin
            ram_we    = 1'b1;
            wr_addr_d = wr_addr_q + AddrOne;
`ifdef KYBER_PK_CHKSUM_EN
            chk_d     = chk_q ^ ld_data;
`endif
            if (wr_addr_q == n_q - AddrOne) begin
              if (pend_q || req_q) begin
                state_d  = StSend;
                rd_cnt_d = '0;
                pend_d   = 1'b0;
              end else begin
                state_d = StReady;
              end
            end
          end
        end
        StReady: begin
          if (req_q || pend_q) begin
            state_d  = StSend;
            rd_cnt_d = '0;
            pend_d   = 1'b0;
          end
        end
        StSend: begin
          if (rd_cnt_q != total) begin
            ram_re   = 1'b1;
            valid_d  = 1'b1;
            rd_cnt_d = rd_cnt_q + AddrOne;
`ifdef KYBER_PK_CHKSUM_EN
            sel_chk_d = (rd_cnt_q == n_q);
`endif
          end else begin
            state_d = StReady;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State registers; reset aborts any load or burst immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      n_q       <= '0;
      wr_addr_q <= '0;
      rd_cnt_q  <= '0;
      pend_q    <= 1'b0;
      req_q     <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
`ifdef KYBER_PK_CHKSUM_EN
      chk_q     <= '0;
      sel_chk_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      wr_addr_q <= wr_addr_d;
      rd_cnt_q  <= rd_cnt_d;
      pend_q    <= pend_d;
      req_q     <= req_pk;
      err_q     <= err_d;
      valid_q   <= valid_d;
`ifdef KYBER_PK_CHKSUM_EN
      chk_q     <= chk_d;
      sel_chk_q <= sel_chk_d;
`endif
    end
  end

  kyber_pk_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we),
    .waddr_i (wr_addr_q),
    .wdata_i (ld_data),
    .re_i    (ram_re),
    .raddr_i (rd_cnt_q),
    .rdata_o (ram_rdata)
  );

  assign ld_ready = (state_q == StLoad);
  assign ready_pk = (state_q == StReady);
  assign valid    = valid_q;
  assign err      = err_q;

`ifdef KYBER_PK_CHKSUM_EN
  assign dout = sel_chk_q ? chk_q : ram_rdata;
`else
  assign dout = ram_rdata;
`endif

endmodule
